// File: rtl/difftest_commit_monitor_pkg.sv
// difftest_commit_monitor_pkg: halt encoding, trap codes and FSM states shared by the commit monitor
package difftest_commit_monitor_pkg;
  localparam logic [31:0] HALT_INSTR_DEF = 32'h8000_0000;
  localparam logic [7:0] TRAP_GOOD = 8'h00;
  localparam logic [7:0] TRAP_TIMEOUT = 8'hFF;
  typedef enum logic [1:0] {RUN = 2'd0, HALTED = 2'd1, TIMEOUT = 2'd2} state_t;
endpackage

// File: rtl/commit_compactor.sv
// commit_compactor: truncates lanes after the first halt, packs valid lanes downward and counts them
module commit_compactor
  import difftest_commit_monitor_pkg::*;
#(
  parameter int COMMIT_WIDTH = 2,
  parameter logic [31:0] HALT_INSTR = HALT_INSTR_DEF,
  localparam int KW = $clog2(COMMIT_WIDTH + 1)
) (
  input  logic [COMMIT_WIDTH-1:0]    valid,
  input  logic [32*COMMIT_WIDTH-1:0] pc,
  input  logic [32*COMMIT_WIDTH-1:0] instr,
  input  logic [COMMIT_WIDTH-1:0]    wreg,
  input  logic [5*COMMIT_WIDTH-1:0]  waddr,
  input  logic [32*COMMIT_WIDTH-1:0] wdata,
  output logic [COMMIT_WIDTH-1:0]    pk_valid,
  output logic [8*COMMIT_WIDTH-1:0]  pk_index,
  output logic [32*COMMIT_WIDTH-1:0] pk_pc,
  output logic [32*COMMIT_WIDTH-1:0] pk_instr,
  output logic [COMMIT_WIDTH-1:0]    pk_wreg,
  output logic [5*COMMIT_WIDTH-1:0]  pk_waddr,
  output logic [32*COMMIT_WIDTH-1:0] pk_wdata,
  output logic [KW-1:0]              k,
  output logic                       halt,
  output logic [31:0]                halt_pc
);
  int n;
  always_comb begin
    pk_valid = '0;
    pk_index = '0;
    pk_pc = '0;
    pk_instr = '0;
    pk_wreg = '0;
    pk_waddr = '0;
    pk_wdata = '0;
    halt = 1'b0;
    halt_pc = '0;
    n = 0;
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      if (valid[i] && !halt) begin
        for (int j = 0; j < COMMIT_WIDTH; j++) begin
          if (j == n) begin
            pk_valid[j] = 1'b1;
            pk_index[j*8 +: 8] = 8'(j);
            pk_pc[j*32 +: 32] = pc[i*32 +: 32];
            pk_instr[j*32 +: 32] = instr[i*32 +: 32];
            pk_wreg[j] = wreg[i];
            pk_waddr[j*5 +: 5] = waddr[i*5 +: 5];
            pk_wdata[j*32 +: 32] = wdata[i*32 +: 32];
          end
        end
        if (instr[i*32 +: 32] == HALT_INSTR) begin
          halt = 1'b1;
          halt_pc = pc[i*32 +: 32];
        end
        n = n + 1;
      end
    end
    k = KW'(n);
  end
endmodule

// File: rtl/difftest_commit_monitor.sv
// difftest_commit_monitor: registered, packed commit stream for difftest with perf counters and a sticky trap.
// Defining COMMIT_WATCHDOG_EN adds a commit-starvation watchdog that traps with code 8'hFF.
module difftest_commit_monitor
  import difftest_commit_monitor_pkg::*;
#(
  parameter int COMMIT_WIDTH = 2,
  parameter logic [31:0] HALT_INSTR = HALT_INSTR_DEF,
  parameter int WDOG_CYCLES = 20000
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic [COMMIT_WIDTH-1:0]    commit_valid_i,
  input  logic [32*COMMIT_WIDTH-1:0] commit_pc_i,
  input  logic [32*COMMIT_WIDTH-1:0] commit_instr_i,
  input  logic [COMMIT_WIDTH-1:0]    commit_wreg_i,
  input  logic [5*COMMIT_WIDTH-1:0]  commit_waddr_i,
  input  logic [32*COMMIT_WIDTH-1:0] commit_wdata_i,
  input  logic [7:0]                 halt_code_i,
  input  logic                       perf_clean_i,
  output logic [COMMIT_WIDTH-1:0]    out_valid_o,
  output logic [8*COMMIT_WIDTH-1:0]  out_index_o,
  output logic [32*COMMIT_WIDTH-1:0] out_pc_o,
  output logic [32*COMMIT_WIDTH-1:0] out_instr_o,
  output logic [COMMIT_WIDTH-1:0]    out_wreg_o,
  output logic [5*COMMIT_WIDTH-1:0]  out_waddr_o,
  output logic [32*COMMIT_WIDTH-1:0] out_wdata_o,
  output logic [63:0]                cycle_cnt_o,
  output logic [63:0]                instr_cnt_o,
  output logic                       trap_valid_o,
  output logic [7:0]                 trap_code_o,
  output logic [31:0]                trap_pc_o
);
  localparam int KW = $clog2(COMMIT_WIDTH + 1);
  state_t state, state_nxt;
  logic run, halt, timeout;
  logic [31:0] halt_pc, timeout_pc;
  logic [KW-1:0] k;
  logic [COMMIT_WIDTH-1:0] act_valid, pk_valid, pk_wreg;
  logic [8*COMMIT_WIDTH-1:0] pk_index;
  logic [5*COMMIT_WIDTH-1:0] pk_waddr;
  logic [32*COMMIT_WIDTH-1:0] pk_pc, pk_instr, pk_wdata;
  assign run = state == RUN;
  // Terminal states see no commits, so packed data, k and halt all go quiet there
  assign act_valid = run ? commit_valid_i : '0;
  commit_compactor #(.COMMIT_WIDTH(COMMIT_WIDTH), .HALT_INSTR(HALT_INSTR)) u_compactor (
    .valid(act_valid), .pc(commit_pc_i), .instr(commit_instr_i), .wreg(commit_wreg_i),
    .waddr(commit_waddr_i), .wdata(commit_wdata_i), .pk_valid(pk_valid), .pk_index(pk_index),
    .pk_pc(pk_pc), .pk_instr(pk_instr), .pk_wreg(pk_wreg), .pk_waddr(pk_waddr),
    .pk_wdata(pk_wdata), .k(k), .halt(halt), .halt_pc(halt_pc)
  );
`ifdef COMMIT_WATCHDOG_EN
  logic [31:0] wdog, last_pc, pk_last_pc;
  always_comb begin
    pk_last_pc = last_pc;
    for (int j = 0; j < COMMIT_WIDTH; j++) pk_last_pc = pk_valid[j] ? pk_pc[j*32 +: 32] : pk_last_pc;
  end
  assign timeout = run && k == '0 && wdog == 32'(WDOG_CYCLES);
  assign timeout_pc = last_pc;
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wdog <= '0;
      last_pc <= '0;
    end else if (run) begin
      wdog <= k != '0 ? '0 : wdog + 32'd1;
      last_pc <= pk_last_pc;
    end
  end
`else
  logic unused_wdog;
  assign unused_wdog = WDOG_CYCLES == 0;
  assign timeout = 1'b0;
  assign timeout_pc = '0;
`endif
  always_ff @(posedge clock) state <= !reset_n ? RUN : state_nxt;
  always_comb state_nxt = halt ? HALTED : (timeout ? TIMEOUT : state);
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      out_valid_o <= '0;
      out_index_o <= '0;
      out_pc_o <= '0;
      out_instr_o <= '0;
      out_wreg_o <= '0;
      out_waddr_o <= '0;
      out_wdata_o <= '0;
      cycle_cnt_o <= '0;
      instr_cnt_o <= '0;
      trap_valid_o <= 1'b0;
      trap_code_o <= TRAP_GOOD;
      trap_pc_o <= '0;
    end else begin
      out_valid_o <= pk_valid;
      out_index_o <= pk_index;
      out_pc_o <= pk_pc;
      out_instr_o <= pk_instr;
      out_wreg_o <= pk_wreg;
      out_waddr_o <= pk_waddr;
      out_wdata_o <= pk_wdata;
      cycle_cnt_o <= perf_clean_i ? '0 : cycle_cnt_o + 64'(run);
      instr_cnt_o <= perf_clean_i ? '0 : instr_cnt_o + 64'(k);
      if (halt || timeout) begin
        trap_valid_o <= 1'b1;
        trap_code_o <= halt ? halt_code_i : TRAP_TIMEOUT;
        trap_pc_o <= halt ? halt_pc : timeout_pc;
      end
    end
  end
endmodule
